letc_core_limp_axi_bridge: RTL

//  Sits downstream of the LIMP bus in LETC Core: services one LIMP request at a time and turns it into a

---
 rtl/letc_core_pkg.sv | 10 +
 rtl/letc_core_limp_lane_steer.sv | 22 ++
 rtl/letc_core_limp_axi_bridge.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/letc_core_pkg.sv
// letc_core_pkg: shared LIMP/AXI types for the LETC core bus bridge.
package letc_core_pkg;
    typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} size_e;
    typedef enum logic [1:0] {AXI_OKAY, AXI_EXOKAY, AXI_SLVERR, AXI_DECERR} axi_resp_e;
    localparam int LIMP_AXI_LANES = 4;
    // The unused encoding 3 behaves as a full word.
    function automatic size_e norm_size(input logic [1:0] s);
        return s == 2'd3 ? WORD : size_e'(s);
    endfunction
endpackage

// File: rtl/letc_core_limp_lane_steer.sv
// letc_core_limp_lane_steer: combinational byte-lane alignment between right-aligned LIMP data and AXI lanes.
module letc_core_limp_lane_steer
    import letc_core_pkg::*;
(
    input  size_e                     size_i,
    input  logic [1:0]                off_i,
    input  logic [31:0]               wdata_i,
    input  logic [31:0]               rdata_axi_i,
    output logic [LIMP_AXI_LANES-1:0] wstrb_o,
    output logic [31:0]               wdata_o,
    output logic [31:0]               rdata_o
);
    logic [1:0]  off;
    logic [31:0] rshift;
    always_comb begin
        off     = size_i == WORD ? 2'd0 : size_i == HALF ? {off_i[1], 1'b0} : off_i;
        wstrb_o = size_i == WORD ? 4'b1111 : (size_i == HALF ? 4'b0011 : 4'b0001) << off;
        wdata_o = size_i == WORD ? wdata_i : size_i == HALF ? {2{wdata_i[15:0]}} : {4{wdata_i[7:0]}};
        rshift  = rdata_axi_i >> {off, 3'b000};
        rdata_o = size_i == WORD ? rshift : size_i == HALF ? {16'h0, rshift[15:0]} : {24'h0, rshift[7:0]};
    end
endmodule

// File: rtl/letc_core_limp_axi_bridge.sv
// letc_core_limp_axi_bridge: one-at-a-time LIMP to single-beat AXI4-Lite bridge.
// Define LETC_LIMP_FAULT_EN to add o_limp_fault (misalignment and error-response reporting).
module letc_core_limp_axi_bridge
    import letc_core_pkg::*;
#(
    parameter int ADDR_W = 34,
    parameter int DATA_W = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_limp_valid,
    output logic                      o_limp_ready,
    input  logic                      i_limp_wen_nren,
    input  logic                      i_limp_uncacheable,
    input  logic [1:0]                i_limp_size,
    input  logic [ADDR_W-1:0]         i_limp_addr,
    input  logic [DATA_W-1:0]         i_limp_wdata,
    output logic [DATA_W-1:0]         o_limp_rdata,
    output logic                      o_axi_awvalid,
    input  logic                      i_axi_awready,
    output logic [ADDR_W-1:0]         o_axi_awaddr,
    output logic                      o_axi_wvalid,
    input  logic                      i_axi_wready,
    output logic [31:0]               o_axi_wdata,
    output logic [LIMP_AXI_LANES-1:0] o_axi_wstrb,
    input  logic                      i_axi_bvalid,
    output logic                      o_axi_bready,
    input  logic [1:0]                i_axi_bresp,
    output logic                      o_axi_arvalid,
    input  logic                      i_axi_arready,
    output logic [ADDR_W-1:0]         o_axi_araddr,
    input  logic                      i_axi_rvalid,
    output logic                      o_axi_rready,
    input  logic [31:0]               i_axi_rdata,
    input  logic [1:0]                i_axi_rresp
`ifdef LETC_LIMP_FAULT_EN
    ,
    output logic                      o_limp_fault
`endif
);
    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AWW, S_B, S_DONE} state_e;

    if (DATA_W != 32) begin : g_bad_width
        $error("letc_core_limp_axi_bridge supports only DATA_W == 32");
    end

    state_e                    state_q, state_d;
    size_e                     size_q, size_in;
    logic [ADDR_W-1:0]         addr_q, addr_in;
    logic [LIMP_AXI_LANES-1:0] wstrb_q, st_wstrb;
    logic [31:0]               wdata_q, rdata_q, st_wdata, st_rdata;
    logic                      aw_done_q, w_done_q, fault_req;
    logic                      unused_ok;

    // While idle the steering sees the live request so it can be latched already aligned.
    always_comb begin
        size_in = state_q == S_IDLE ? norm_size(i_limp_size) : size_q;
`ifdef LETC_LIMP_FAULT_EN
        addr_in   = i_limp_addr;
        fault_req = (size_in == HALF && i_limp_addr[0]) || (size_in == WORD && i_limp_addr[1:0] != 2'd0);
`else
        addr_in   = {i_limp_addr[ADDR_W-1:2], i_limp_addr[1] & (size_in != WORD), i_limp_addr[0] & (size_in == BYTE)};
        fault_req = 1'b0;
`endif
    end

    letc_core_limp_lane_steer u_steer (
        .size_i      (size_in),
        .off_i       (state_q == S_IDLE ? addr_in[1:0] : addr_q[1:0]),
        .wdata_i     (i_limp_wdata),
        .rdata_axi_i (i_axi_rdata),
        .wstrb_o     (st_wstrb),
        .wdata_o     (st_wdata),
        .rdata_o     (st_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (i_limp_valid) state_d = fault_req ? S_DONE : i_limp_wen_nren ? S_AWW : S_AR;
            S_AR:   if (i_axi_arready) state_d = S_R;
            S_R:    if (i_axi_rvalid) state_d = S_DONE;
            S_AWW:  if ((aw_done_q || i_axi_awready) && (w_done_q || i_axi_wready)) state_d = S_B;
            S_B:    if (i_axi_bvalid) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_axi_arvalid = state_q == S_AR;
        o_axi_rready  = state_q == S_R;
        o_axi_awvalid = state_q == S_AWW && !aw_done_q;
        o_axi_wvalid  = state_q == S_AWW && !w_done_q;
        o_axi_bready  = state_q == S_B;
        o_limp_ready  = state_q == S_DONE;
        o_axi_awaddr  = addr_q;
        o_axi_araddr  = addr_q;
        o_axi_wdata   = wdata_q;
        o_axi_wstrb   = wstrb_q;
        o_limp_rdata  = rdata_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q    <= '0;
            size_q    <= BYTE;
            wstrb_q   <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (state_q == S_IDLE && i_limp_valid) begin
                addr_q  <= addr_in;
                size_q  <= size_in;
                wstrb_q <= st_wstrb;
                wdata_q <= st_wdata;
            end
            if (state_q == S_R && i_axi_rvalid) rdata_q <= st_rdata;
            aw_done_q <= state_q == S_AWW && state_d == S_AWW && (aw_done_q || i_axi_awready);
            w_done_q  <= state_q == S_AWW && state_d == S_AWW && (w_done_q || i_axi_wready);
        end
    end

`ifdef LETC_LIMP_FAULT_EN
    logic fault_q;
    always_ff @(posedge i_clk) begin
        if (i_rst) fault_q <= 1'b0;
        else if (state_q == S_IDLE && i_limp_valid) fault_q <= fault_req;
        else if (state_q == S_R && i_axi_rvalid) fault_q <= axi_resp_e'(i_axi_rresp) != AXI_OKAY;
        else if (state_q == S_B && i_axi_bvalid) fault_q <= axi_resp_e'(i_axi_bresp) != AXI_OKAY;
    end
    assign o_limp_fault = state_q == S_DONE && fault_q;
    assign unused_ok    = i_limp_uncacheable;
`else
    assign unused_ok = ^{i_limp_uncacheable, i_axi_rresp, i_axi_bresp};
`endif
endmodule
